// File: rtl/i2cs_fifo_push_arbiter.sv
// Round-robin push-port arbiter for the I2C slave FIFO.
// Two byte requesters share one FIFO write port in bounded bursts.
module i2cs_fifo_push_arbiter #(
  parameter int         MAX_BURST = 16,
  parameter logic [2:0] WM_FLAGS  = 3'b100
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req0_i,
  input  logic [7:0] data0_i,
  input  logic       last0_i,
  output logic       ack0_o,
  input  logic       req1_i,
  input  logic [7:0] data1_i,
  input  logic       last1_i,
  output logic       ack1_o,
  input  logic       fifo_full_i,
  input  logic [2:0] fifo_flags_i,
  output logic       push_o,
  output logic [7:0] wr_data_o,
  output logic [1:0] grant_o,
  output logic       irq_o,
  input  logic       irq_clr_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       last_served;
  logic [7:0] beat_cnt;
  logic       own_req;
  logic       own_last;
  logic       at_limit;
  logic       burst_end;

  assign at_limit  = (beat_cnt == 8'(MAX_BURST - 1));
  assign burst_end = ~own_req |
                     (push_o & (own_last | at_limit));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ties go to whoever was not served last.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req0_i & req1_i) begin
          state_nxt = last_served ? OWN0 : OWN1;
        end else if (req0_i) begin
          state_nxt = OWN0;
        end else if (req1_i) begin
          state_nxt = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (burst_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    own_req   = 1'b0;
    own_last  = 1'b0;
    ack0_o    = 1'b0;
    ack1_o    = 1'b0;
    push_o    = 1'b0;
    wr_data_o = 8'h00;
    grant_o   = 2'b00;
    unique case (1'b1)
      (state == OWN0): begin
        own_req   = req0_i;
        own_last  = last0_i;
        ack0_o    = req0_i & ~fifo_full_i;
        push_o    = ack0_o;
        wr_data_o = ack0_o ? data0_i : 8'h00;
        grant_o   = 2'b01;
      end
      (state == OWN1): begin
        own_req   = req1_i;
        own_last  = last1_i;
        ack1_o    = req1_i & ~fifo_full_i;
        push_o    = ack1_o;
        wr_data_o = ack1_o ? data1_i : 8'h00;
        grant_o   = 2'b10;
      end
      default: begin
        own_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_served <= 1'b1;
      beat_cnt    <= 8'd0;
    end else if ((state != IDLE) && burst_end) begin
      last_served <= (state == OWN1);
      beat_cnt    <= 8'd0;
    end else if (push_o) begin
      beat_cnt    <= beat_cnt + 8'd1;
    end
  end

  // Set dominates clear while the FIFO stays above the watermark.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_o <= 1'b0;
    end else if (fifo_flags_i >= WM_FLAGS) begin
      irq_o <= 1'b1;
    end else if (irq_clr_i) begin
      irq_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2cs_fifo_push_arbiter.sv
// Scoreboard bench for i2cs_fifo_push_arbiter.
// A requester-level model predicts every cycle; a monitor compares.
module tb_i2cs_fifo_push_arbiter;

  localparam int MAXB = 16;
  localparam logic [2:0] WM = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, last0, last1;
  logic [7:0] d0, d1;
  logic       ack0, ack1;
  logic       full, clr;
  logic [2:0] flags;
  logic       push;
  logic [7:0] wdata;
  logic [1:0] grant;
  logic       irq;

  i2cs_fifo_push_arbiter #(.MAX_BURST(MAXB), .WM_FLAGS(WM)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .data0_i(d0), .last0_i(last0), .ack0_o(ack0),
    .req1_i(req1), .data1_i(d1), .last1_i(last1), .ack1_o(ack1),
    .fifo_full_i(full), .fifo_flags_i(flags),
    .push_o(push), .wr_data_o(wdata), .grant_o(grant),
    .irq_o(irq), .irq_clr_i(clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] grant;
    logic       push;
    logic [7:0] data;
    logic       ack0;
    logic       ack1;
    logic       irq;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: owner -1 = nobody, else requester index.
  int m_own = -1;
  int m_prev = 1;
  int m_beats = 0;
  bit m_irq = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("grant", grant, e.grant);
      chk("push", push, e.push);
      chk("wr_data", wdata, e.data);
      chk("ack0", ack0, e.ack0);
      chk("ack1", ack1, e.ack1);
      chk("irq", irq, e.irq);
    end else if (push) begin
      chk("unexpected_push", push, 0);
    end
  end

  // Predict this cycle, advance the model, then move to the next cycle.
  task automatic tick(output bit a0, output bit a1);
    exp_t e;
    bit   rq, lst, a;
    if (!rst_n) begin
      m_own = -1; m_prev = 1; m_beats = 0; m_irq = 0;
    end
    a0 = (m_own == 0) && req0 && !full;
    a1 = (m_own == 1) && req1 && !full;
    e.grant = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    e.push  = a0 | a1;
    e.data  = a0 ? d0 : (a1 ? d1 : 8'h00);
    e.ack0  = a0;
    e.ack1  = a1;
    e.irq   = m_irq;
    sb.push_back(e);
    if (rst_n) begin
      if (m_own < 0) begin
        if (req0 && req1) m_own = 1 - m_prev;
        else if (req0) m_own = 0;
        else if (req1) m_own = 1;
      end else begin
        rq  = (m_own == 0) ? req0 : req1;
        lst = (m_own == 0) ? last0 : last1;
        a   = a0 | a1;
        if (!rq || (a && (lst || (m_beats + 1 == MAXB)))) begin
          m_prev = m_own; m_own = -1; m_beats = 0;
        end else if (a) begin
          m_beats++;
        end
      end
      if (flags >= WM) m_irq = 1;
      else if (clr) m_irq = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; last0 = 0; last1 = 0;
    d0 = 0; d1 = 0; full = 0; clr = 0; flags = 3'b000;
  endtask

  initial begin
    bit a0, a1;
    int k0, k1, cnt;
    rst_n = 0;
    idle_inputs();
    @(posedge clk); #1;
    tick(a0, a1);
    tick(a0, a1);
    rst_n = 1;
    tick(a0, a1);

    // Short burst A0..A3 terminated by last.
    k0 = 0;
    for (int i = 0; i < 8; i++) begin
      req0 = (k0 < 4); d0 = 8'hA0 + 8'(k0); last0 = (k0 == 3);
      tick(a0, a1);
      if (a0) k0++;
    end
    idle_inputs();
    tick(a0, a1);

    // Both held, no last: MAX_BURST-limited alternation.
    k0 = 0; k1 = 0;
    for (int i = 0; i < 60; i++) begin
      req0 = 1; req1 = 1; d0 = 8'(k0); d1 = 8'h80 + 8'(k1);
      tick(a0, a1);
      if (a0) k0++;
      if (a1) k1++;
    end
    idle_inputs();
    tick(a0, a1);
    tick(a0, a1);

    // FIFO full for 5 cycles mid-burst.
    k0 = 0; cnt = 0;
    for (int i = 0; i < 30; i++) begin
      req0 = 1; d0 = 8'h40 + 8'(k0);
      full = (k0 == 4) && (cnt < 5);
      if (full) cnt++;
      tick(a0, a1);
      if (a0) k0++;
    end
    idle_inputs();
    tick(a0, a1);

    // Owner withdraws after 3 bytes; the other requester follows.
    k0 = 0; k1 = 0;
    for (int i = 0; i < 12; i++) begin
      req0 = (k0 < 3); d0 = 8'h10 + 8'(k0);
      req1 = 1; d1 = 8'h20 + 8'(k1); last1 = (k1 == 1);
      tick(a0, a1);
      if (a0) k0++;
      if (a1) k1++;
    end
    idle_inputs();
    tick(a0, a1);

    // Sticky watermark interrupt.
    flags = 3'b011; tick(a0, a1);
    flags = 3'b100; tick(a0, a1);
    clr = 1;        tick(a0, a1);
    tick(a0, a1);
    flags = 3'b011; tick(a0, a1);
    clr = 0;        tick(a0, a1);
    tick(a0, a1);

    // Reset pulsed at beat 7, with both requesters waiting afterwards.
    idle_inputs();
    k0 = 0;
    for (int i = 0; i < 9; i++) begin
      req1 = 1; d1 = 8'h60 + 8'(k0);
      tick(a0, a1);
      if (a1) k0++;
    end
    rst_n = 0; tick(a0, a1);
    tick(a0, a1);
    rst_n = 1; req0 = 1; req1 = 1; d0 = 8'h77; d1 = 8'h88;
    for (int i = 0; i < 4; i++) tick(a0, a1);
    idle_inputs();
    tick(a0, a1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      d0 = 8'($urandom); d1 = 8'($urandom);
      last0 = ($urandom_range(0, 9) == 0);
      last1 = ($urandom_range(0, 9) == 0);
      full  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) flags = 3'($urandom);
      clr   = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      tick(a0, a1);
    end
    rst_n = 1;
    idle_inputs();
    tick(a0, a1);
    @(negedge clk);
    #1;
    if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
